// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns (bars, solid, grid, black).
// Outputs are registered from the current counter position, so they lag the counters by one enabled cycle.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic [11:0] hcount_o,
  output logic [10:0] vcount_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

  logic [11:0] hcnt;
  logic [10:0] vcnt;
  logic [11:0] bar_cnt;
  logic [2:0]  bar_idx;
  logic [1:0]  pat_q;

  logic        hblank, vblank, hsync, vsync, de, first_px, h_last, v_last;
  logic [1:0]  pat_eff;
  logic [23:0] bar_rgb, rgb_d;

  always_comb begin
    hblank   = (hcnt >= H_ACT);
    vblank   = (vcnt >= V_ACT);
    hsync    = (hcnt >= HS_BEG) && (hcnt < HS_END);
    vsync    = (vcnt >= VS_BEG) && (vcnt < VS_END);
    de       = ~hblank & ~vblank;
    first_px = (hcnt == 12'd0) && (vcnt == 11'd0);
    h_last   = (hcnt == H_LAST);
    v_last   = (vcnt == V_LAST);
    // A new selection takes effect from the very first pixel of the frame it is sampled in.
    pat_eff  = first_px ? pat_sel_i : pat_q;
  end

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (de) begin
      case (pat_eff)
        2'd0: rgb_d = bar_rgb;
        2'd1: rgb_d = 24'hFF5A43;
        2'd2: rgb_d = ((hcnt[5:0] == 6'd0) || (vcnt[5:0] == 6'd0)) ? 24'hFFFFFF : 24'h000000;
        default: rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt          <= '0;
      vcnt          <= '0;
      bar_cnt       <= BAR_LAST;
      bar_idx       <= '0;
      pat_q         <= '0;
      vh_blank_o    <= 2'b11;
      dvh_sync_o    <= 3'b000;
      vid_rgb_o     <= '0;
      hcount_o      <= '0;
      vcount_o      <= '0;
      frame_start_o <= 1'b0;
    end else if (cen_i) begin
      vh_blank_o    <= {vblank, hblank};
      dvh_sync_o    <= {de, vsync, hsync};
      vid_rgb_o     <= rgb_d;
      hcount_o      <= hcnt;
      vcount_o      <= vcnt;
      frame_start_o <= first_px;
      if (first_px) pat_q <= pat_sel_i;

      // Bar index runs off a per-bar down-counter, so no divide by bar width is needed.
      if (h_last) begin
        hcnt    <= '0;
        bar_cnt <= BAR_LAST;
        bar_idx <= '0;
        vcnt    <= v_last ? 11'd0 : vcnt + 11'd1;
      end else begin
        hcnt <= hcnt + 12'd1;
        if (bar_cnt == 12'd0) begin
          bar_cnt <= BAR_LAST;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt - 12'd1;
        end
      end
    end
  end

endmodule
